// File: rtl/sort_arbiter.sv
// sort_arbiter: round-robin sharing of one selection_sort instance between NREQ requesters with timeout
module sort_arbiter #(
  parameter int NREQ = 4,
  parameter int INPUTVALS = 16,
  parameter int INPUTBITWIDTHS = 32,
  parameter int TIMEOUT = 1024,
  localparam int PW = $clog2(INPUTVALS) + 1,
  localparam int CW = $clog2(TIMEOUT),
  localparam int OW = $clog2(NREQ)
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic [NREQ-1:0]                                     req_valid,
  input  logic [NREQ-1:0][INPUTVALS-1:0][INPUTBITWIDTHS-1:0]  req_data,
  output logic [NREQ-1:0]                                     req_ready,
  output logic [NREQ-1:0]                                     rsp_valid,
  output logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]            rsp_sorted,
  output logic [INPUTVALS-1:0][PW-1:0]                        rsp_positions,
  output logic                                                rsp_error,
  output logic                                                sort_start,
  output logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]            sort_data,
  input  logic                                                sort_done,
  input  logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]            sort_sorted,
  input  logic [INPUTVALS-1:0][PW-1:0]                        sort_positions,
  input  logic                                                sort_error,
  output logic                                                busy
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [OW-1:0] rr_ptr, owner, grant, idx;
  logic [CW-1:0] cnt;
  logic any, accept, timeout, finish;
  always_comb begin
    grant = rr_ptr;
    idx = rr_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = OW'((int'(rr_ptr) + k) % NREQ);
      grant = req_valid[idx] ? idx : grant;
    end
    any = |req_valid;
    accept = (state == IDLE) && any;
    timeout = cnt == CW'(TIMEOUT - 1);
    finish = (state == WAIT) && (sort_done || timeout);
    req_ready = accept ? NREQ'(1) << grant : '0;
    case (state)
      IDLE:    state_n = any ? LAUNCH : IDLE;
      LAUNCH:  state_n = WAIT;
      WAIT:    state_n = (sort_done || timeout) ? RESP : WAIT;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      cnt <= '0;
      sort_data <= '0;
      sort_start <= 1'b0;
      busy <= 1'b0;
      rsp_valid <= '0;
      rsp_sorted <= '0;
      rsp_positions <= '0;
      rsp_error <= 1'b0;
    end else begin
      state <= state_n;
      sort_start <= state_n == LAUNCH;
      busy <= state_n != IDLE;
      rsp_valid <= (state_n == RESP) ? NREQ'(1) << owner : '0;
      if (accept) begin
        sort_data <= req_data[grant];
        owner <= grant;
      end
      if (state == LAUNCH) cnt <= '0;
      else if (state == WAIT && !sort_done && !timeout) cnt <= cnt + 1'b1;
      if (finish) begin
        rsp_sorted <= sort_done ? sort_sorted : '0;
        rsp_positions <= sort_done ? sort_positions : '0;
        rsp_error <= sort_done ? sort_error : 1'b1;
      end
      if (state == RESP) rr_ptr <= (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
    end
  end
endmodule

// File: tb/tb_sort_arbiter.sv
// tb_sort_arbiter: table, random and hand-written sequences against a behavioural arbiter/sorter model
module tb_sort_arbiter;
  localparam int N = 4, V = 16, W = 32, TO = 8, PW = 5;
  typedef logic [V-1:0][W-1:0] list_t;
  typedef logic [V-1:0][PW-1:0] pos_t;
  typedef struct {
    logic [N-1:0] valid;
    int lat;
    bit err;
    bit desc;
    int g;
  } vec_t;
  logic clk = 0, reset = 0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0][V-1:0][W-1:0] req_data = '0;
  logic [N-1:0] req_ready, rsp_valid;
  list_t rsp_sorted, sort_data, sort_sorted = '0;
  pos_t rsp_positions, sort_positions = '0;
  logic rsp_error, sort_start, busy, sort_done = 0, sort_error = 0;
  int tests = 0, fails = 0, cyc = 0, rr = 0, lat_cfg = 0, sc = 0;
  bit sorter_auto = 1, err_cfg = 0;
  list_t job;
  vec_t tbl[8];

  sort_arbiter #(.NREQ(N), .INPUTVALS(V), .INPUTBITWIDTHS(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_sorted(rsp_sorted),
    .rsp_positions(rsp_positions), .rsp_error(rsp_error), .sort_start(sort_start),
    .sort_data(sort_data), .sort_done(sort_done), .sort_sorted(sort_sorted),
    .sort_positions(sort_positions), .sort_error(sort_error), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void ref_sort(input list_t in, output list_t s, output pos_t p);
    bit used[V];
    int best;
    for (int j = 0; j < V; j++) used[j] = 0;
    for (int k = 0; k < V; k++) begin
      best = -1;
      for (int j = 0; j < V; j++)
        if (!used[j] && (best < 0 || in[j] < in[best])) best = j;
      used[best] = 1;
      s[k] = in[best];
      p[k] = PW'(best);
    end
  endfunction

  function automatic int model_grant(input logic [N-1:0] v, input int p);
    int best = -1, bd = N;
    for (int i = 0; i < N; i++)
      if (v[i] && ((i - p + N) % N) < bd) begin
        bd = (i - p + N) % N;
        best = i;
      end
    return best;
  endfunction

  // sorter stand-in: done pulse lat_cfg cycles after the start pulse, never when lat_cfg is 0
  always @(posedge clk) begin
    #1;
    if (sorter_auto) begin
      sort_done = 0;
      if (sort_start) begin
        sc = lat_cfg;
        job = sort_data;
      end else if (sc > 0) begin
        sc--;
        if (sc == 0) begin
          sort_done = 1;
          ref_sort(job, sort_sorted, sort_positions);
          sort_error = err_cfg;
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [511:0] a, input logic [511:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic wait_ready;
    int n = 0;
    while (req_ready == 0 && n < 40) begin
      step;
      n++;
    end
  endtask

  task automatic wait_rsp;
    int n = 0;
    while (rsp_valid == 0 && n < 200) begin
      step;
      n++;
    end
  endtask

  task automatic fill(input bit desc, output list_t d[N]);
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < V; k++) d[r][k] = desc ? 32'(1000 - k * 7) : 32'($urandom);
      req_data[r] = d[r];
    end
  endtask

  task automatic run_job(input logic [N-1:0] v, input int lat, input bit err, input bit desc, input int g);
    list_t d[N];
    list_t s;
    pos_t p;
    int t;
    bit to;
    fill(desc, d);
    lat_cfg = lat;
    err_cfg = err;
    req_valid = v;
    #1;
    wait_ready;
    t = cyc;
    chk("req_ready", req_ready, N'(1) << g);
    step;
    req_valid = '0;
    chk("sort_start", sort_start, 1);
    chk("busy_launch", busy, 1);
    chk("sort_data", sort_data, d[g]);
    to = lat == 0 || lat > TO;
    wait_rsp;
    chk("rsp_latency", cyc - t, to ? 2 + TO : 2 + lat);
    ref_sort(d[g], s, p);
    chk("rsp_valid", rsp_valid, N'(1) << g);
    chk("rsp_sorted", rsp_sorted, to ? '0 : s);
    chk("rsp_positions", rsp_positions, to ? '0 : p);
    chk("rsp_error", rsp_error, to ? 1 : err);
    step;
    chk("rsp_valid_pulse", rsp_valid, 0);
    chk("busy_idle", busy, 0);
    rr = (g + 1) % N;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    list_t d[N];
    list_t s;
    pos_t p;
    logic [N-1:0] v;
    int g, t, seen;
    tbl[0] = '{4'b0010, 20, 0, 1, 1};
    tbl[1] = '{4'b0011, 3, 0, 0, 0};
    tbl[2] = '{4'b1001, 1, 1, 0, 3};
    tbl[3] = '{4'b1100, 0, 0, 0, 2};
    tbl[4] = '{4'b0111, 8, 0, 0, 0};
    tbl[5] = '{4'b1111, 9, 0, 0, 1};
    tbl[6] = '{4'b0001, 2, 0, 0, 0};
    tbl[7] = '{4'b1010, 4, 1, 1, 1};
    repeat (3) step;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_sort_start", sort_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_rsp_sorted", rsp_sorted, 0);
    chk("rst_rsp_positions", rsp_positions, 0);
    chk("rst_sort_data", sort_data, 0);
    reset = 1;
    step;
    // all requesters held high from reset
    rr = 0;
    lat_cfg = 2;
    err_cfg = 0;
    fill(0, d);
    req_valid = '1;
    #1;
    for (int j = 0; j < 5; j++) begin
      wait_ready;
      g = model_grant('1, rr);
      chk("rr_grant", req_ready, N'(1) << g);
      rr = (g + 1) % N;
      step;
      if (j == 4) req_valid = '0;
    end
    wait_rsp;
    step;
    reset = 0;
    step;
    reset = 1;
    rr = 0;
    step;
    for (int i = 0; i < 8; i++) run_job(tbl[i].valid, tbl[i].lat, tbl[i].err, tbl[i].desc, tbl[i].g);
    for (int i = 0; i < 20; i++) begin
      v = N'($urandom_range(1, 15));
      run_job(v, $urandom_range(1, 10), 1'($urandom_range(0, 1)), 0, model_grant(v, rr));
    end
    // stale level-high done carried into the next job
    sorter_auto = 0;
    sort_done = 1;
    sort_sorted = {V{32'hdeadbeef}};
    sort_positions = '1;
    sort_error = 1;
    fill(0, d);
    v = 4'b0110;
    g = model_grant(v, rr);
    req_valid = v;
    #1;
    wait_ready;
    t = cyc;
    chk("stale_ready", req_ready, N'(1) << g);
    step;
    req_valid = '0;
    chk("stale_launch", rsp_valid, 0);
    step;
    chk("stale_wait0", rsp_valid, 0);
    ref_sort(d[g], s, p);
    sort_sorted = s;
    sort_positions = p;
    sort_error = 0;
    step;
    chk("stale_rsp_valid", rsp_valid, N'(1) << g);
    chk("stale_latency", cyc - t, 3);
    chk("stale_sorted", rsp_sorted, s);
    chk("stale_positions", rsp_positions, p);
    chk("stale_error", rsp_error, 0);
    sort_done = 0;
    step;
    sc = 0;
    sorter_auto = 1;
    rr = (g + 1) % N;
    // reset pulse while waiting on the sorter
    lat_cfg = 20;
    fill(0, d);
    req_valid = 4'b0100;
    #1;
    wait_ready;
    step;
    req_valid = '0;
    step;
    step;
    chk("pre_reset_busy", busy, 1);
    reset = 0;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_sort_start", sort_start, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rsp_error", rsp_error, 0);
    chk("arst_rsp_sorted", rsp_sorted, 0);
    chk("arst_rsp_positions", rsp_positions, 0);
    chk("arst_sort_data", sort_data, 0);
    chk("arst_req_ready", req_ready, 0);
    step;
    reset = 1;
    rr = 0;
    seen = 0;
    repeat (25) begin
      step;
      if (rsp_valid != 0) seen++;
    end
    chk("no_rsp_after_reset", seen, 0);
    run_job('1, 3, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
